// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - MEM/WB pipeline register and register-file write port
// Also provides the forwarding bus, sticky halt and error flags, and the retired-instruction count.
module wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_regwrite,
    input  logic [2:0]  mem_writeregsel,
    input  logic [1:0]  mem_wbsel,
    input  logic [15:0] mem_alu_result,
    input  logic [15:0] mem_rd_data,
    input  logic [15:0] mem_pc_plus2,
    input  logic [15:0] mem_imm,
    input  logic        mem_halt,
    input  logic        stall,
    input  logic        flush,
    output logic [2:0]  writeregsel,
    output logic [15:0] writedata,
    output logic        write,
    output logic        fwd_valid,
    output logic [2:0]  fwd_regsel,
    output logic [15:0] fwd_data,
    output logic        halted,
    output logic [15:0] retired,
    output logic        err
);

    logic        wb_valid;
    logic        wb_regwrite;
    logic        wb_halt;
    logic        take;
    logic        illegal;
    logic [15:0] result;

    // A HALT already sitting in WB also blocks capture, so no younger
    // instruction slips in during the cycle before halted rises.
    assign take    = mem_valid & ~stall & ~flush & ~halted & ~(wb_valid & wb_halt);
    assign illegal = wb_valid & wb_halt & wb_regwrite;

    always_comb begin
        result = mem_alu_result;
        case (mem_wbsel)
            2'd0: result = mem_alu_result;
            2'd1: result = mem_rd_data;
            2'd2: result = mem_pc_plus2;
            2'd3: result = mem_imm;
            default: result = mem_alu_result;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_halt     <= 1'b0;
            writeregsel <= 3'd0;
            writedata   <= 16'h0000;
            halted      <= 1'b0;
            err         <= 1'b0;
            retired     <= 16'h0000;
        end else begin
            wb_valid <= take;
            if (take) begin
                writeregsel <= mem_writeregsel;
                wb_regwrite <= mem_regwrite;
                wb_halt     <= mem_halt;
                writedata   <= result;
            end
            if (wb_valid) begin
                retired <= retired + 16'd1;
            end
            if (wb_valid && wb_halt) begin
                halted <= 1'b1;
            end
            if (illegal) begin
                err <= 1'b1;
            end
        end
    end

    // The illegal term suppresses the offending write in the same cycle it sits in WB.
    assign write      = wb_valid & wb_regwrite & ~err & ~illegal & ~halted;
    assign fwd_valid  = write;
    assign fwd_regsel = writeregsel;
    assign fwd_data   = writedata;

endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage with a behavioural reference model
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid = 1'b0, mem_regwrite = 1'b0, mem_halt = 1'b0;
    logic        stall = 1'b0, flush = 1'b0;
    logic [2:0]  mem_writeregsel = 3'd0;
    logic [1:0]  mem_wbsel = 2'd0;
    logic [15:0] mem_alu_result = 16'h0, mem_rd_data = 16'h0, mem_pc_plus2 = 16'h0, mem_imm = 16'h0;
    logic [2:0]  writeregsel, fwd_regsel;
    logic [15:0] writedata, fwd_data, retired;
    logic        write, fwd_valid, halted, err;

    wb_stage dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_regwrite(mem_regwrite), .mem_writeregsel(mem_writeregsel),
        .mem_wbsel(mem_wbsel), .mem_alu_result(mem_alu_result), .mem_rd_data(mem_rd_data),
        .mem_pc_plus2(mem_pc_plus2), .mem_imm(mem_imm), .mem_halt(mem_halt),
        .stall(stall), .flush(flush),
        .writeregsel(writeregsel), .writedata(writedata), .write(write),
        .fwd_valid(fwd_valid), .fwd_regsel(fwd_regsel), .fwd_data(fwd_data),
        .halted(halted), .retired(retired), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Expected register-file writes in program order: {regsel, data}
    logic [18:0] exp_q[$];
    // Reference state: instructions retired, halt seen, illegal HALT seen
    int          m_retired;
    bit          m_halted;
    bit          m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: every write the DUT presents must match the oldest expected write.
    always @(negedge clk) begin
        if (rst === 1'b1 && write === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got rd=%0d data=0x%0h expected none", writeregsel, writedata);
            end else begin
                logic [18:0] e;
                e = exp_q.pop_front();
                if ({writeregsel, writedata} !== e || fwd_valid !== 1'b1
                    || {fwd_regsel, fwd_data} !== e) begin
                    bad++;
                    $display("FAIL write_data: got rd=%0d data=0x%0h fwd=%0b/%0d/0x%0h expected rd=%0d data=0x%0h",
                             writeregsel, writedata, fwd_valid, fwd_regsel, fwd_data, e[18:16], e[15:0]);
                end
            end
        end
    end

    // Present one MEM-stage slot for one cycle and update the reference model.
    task automatic issue(input bit v, input bit rw, input logic [2:0] rd, input logic [1:0] sel,
                         input logic [15:0] alu, input logic [15:0] ld, input logic [15:0] pc,
                         input logic [15:0] imm, input bit h, input bit st, input bit fl);
        logic [15:0] srcs[4];
        mem_valid = v; mem_regwrite = rw; mem_writeregsel = rd; mem_wbsel = sel;
        mem_alu_result = alu; mem_rd_data = ld; mem_pc_plus2 = pc; mem_imm = imm;
        mem_halt = h; stall = st; flush = fl;
        srcs[0] = alu; srcs[1] = ld; srcs[2] = pc; srcs[3] = imm;
        if (v && !st && !fl && !m_halted) begin
            m_retired++;
            if (h) begin
                m_halted = 1'b1;
                if (rw) m_err = 1'b1;
            end else if (rw) begin
                exp_q.push_back({rd, srcs[sel]});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic check_state(input string tag);
        idle(3);
        chk({tag, "_retired"}, {16'h0, retired}, m_retired & 32'hFFFF);
        chk({tag, "_halted"}, {31'h0, halted}, {31'h0, m_halted});
        chk({tag, "_err"}, {31'h0, err}, {31'h0, m_err});
        chk({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #3;
        exp_q.delete();
        m_retired = 0; m_halted = 1'b0; m_err = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        m_retired = 0; m_halted = 1'b0; m_err = 1'b0;
        do_reset();
        chk("rst_write", {31'h0, write}, 0);
        chk("rst_fwd_valid", {31'h0, fwd_valid}, 0);
        chk("rst_regsel", {29'h0, writeregsel}, 0);
        chk("rst_data", {16'h0, writedata}, 0);
        chk("rst_retired", {16'h0, retired}, 0);
        chk("rst_halted", {31'h0, halted}, 0);
        chk("rst_err", {31'h0, err}, 0);

        // Single ALU op: write visible the cycle after capture
        issue(1, 1, 3, 0, 16'h1234, 16'h0, 16'h0, 16'h0, 0, 0, 0);
        chk("alu_write", {31'h0, write}, 1);
        chk("alu_regsel", {29'h0, writeregsel}, 3);
        chk("alu_data", {16'h0, writedata}, 16'h1234);
        idle(1);
        chk("alu_retired", {16'h0, retired}, 1);
        check_state("alu");

        // One of each result source, back to back
        do_reset();
        issue(1, 1, 0, 0, 16'h0001, 16'hAAAA, 16'hBBBB, 16'hCCCC, 0, 0, 0);
        issue(1, 1, 1, 1, 16'h1111, 16'hBEEF, 16'hBBBB, 16'hCCCC, 0, 0, 0);
        issue(1, 1, 2, 2, 16'h1111, 16'hAAAA, 16'h0042, 16'hCCCC, 0, 0, 0);
        issue(1, 1, 7, 3, 16'h1111, 16'hAAAA, 16'hBBBB, 16'hFFF0, 0, 0, 0);
        check_state("srcs");

        // Stall twice then release; then a flushed slot
        issue(1, 1, 5, 0, 16'h5555, 0, 0, 0, 0, 1, 0);
        issue(1, 1, 5, 0, 16'h5555, 0, 0, 0, 0, 1, 0);
        issue(1, 1, 5, 0, 16'h5555, 0, 0, 0, 0, 0, 0);
        check_state("stall");
        issue(1, 1, 6, 0, 16'h6666, 0, 0, 0, 0, 0, 1);
        check_state("flush");

        // Legal HALT followed by ops that must never retire
        do_reset();
        issue(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) issue(1, 1, 3'(i), 0, 16'(i + 16'h100), 0, 0, 0, 0, 0, 0);
        check_state("halt");

        // Illegal HALT with regwrite
        do_reset();
        issue(1, 1, 4, 0, 16'h4444, 0, 0, 0, 1, 0, 0);
        chk("illegal_nowrite", {31'h0, write}, 0);
        issue(1, 1, 2, 0, 16'h2222, 0, 0, 0, 0, 0, 0);
        chk("illegal_err_next", {31'h0, err}, 1);
        check_state("illegal");

        // Randomized traffic with occasional HALTs; reset after each halt episode
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            issue($urandom_range(0, 9) < 8, $urandom_range(0, 3) != 0, 3'($urandom), 2'($urandom),
                  16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 10);
            if (m_halted) begin
                idle(2);
                check_state("rand");
                do_reset();
            end
        end
        check_state("rand_end");

        // Retire counter wrap
        do_reset();
        for (int n = 0; n < 65535; n++) issue(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        chk("wrap_ffff", {16'h0, retired}, 32'hFFFF);
        issue(1, 1, 1, 0, 16'h0BAD, 0, 0, 0, 0, 0, 0);
        idle(2);
        chk("wrap_zero", {16'h0, retired}, 0);
        check_state("wrap");

        // Asynchronous reset while a write is on the port
        issue(1, 1, 6, 3, 0, 0, 0, 16'h7777, 0, 0, 0);
        chk("async_pre_write", {31'h0, write}, 1);
        rst = 1'b0;
        #1;
        chk("async_write", {31'h0, write}, 0);
        chk("async_fwd", {31'h0, fwd_valid}, 0);
        chk("async_regsel", {29'h0, writeregsel}, 0);
        chk("async_data", {16'h0, writedata}, 0);
        chk("async_retired", {16'h0, retired}, 0);
        exp_q.delete();
        m_retired = 0;
        @(posedge clk); #1;
        rst = 1'b1;
        check_state("post_async");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
